// File: rtl/goofy_alu.sv
// Two-operand register ALU with carry/borrow, equality and sticky halt flags.
// One result-producing strobe executes per cycle; compare runs alongside it.
module goofy_alu #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             res,
  input  logic             alu0w,
  input  logic [WIDTH-1:0] alu0d,
  output logic [WIDTH-1:0] alu0o,
  input  logic             alu1w,
  input  logic [WIDTH-1:0] alu1d,
  output logic [WIDTH-1:0] alu1o,
  input  logic             alu_add,
  input  logic             alu_add_ov,
  input  logic             alu_sub,
  input  logic             alu_sub_ov,
  input  logic             alu_and,
  input  logic             alu_or,
  input  logic             alu_not,
  input  logic             alu_cmp,
  input  logic             alu_hlt,
  input  logic             alu_flag_res,
  output logic [WIDTH-1:0] alu_out,
  output logic             alu_flag_ov_o,
  output logic             alu_flag_eq_o,
  output logic             alu_flag_hlt_o
);

  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, out_q, out_d;
  logic             ov_q, ov_d, eq_q, eq_d, hlt_q, hlt_d;
  logic [WIDTH:0]   cin_ext, sum, diff;

  // Carry/borrow lands in bit WIDTH of the widened result.
  assign cin_ext = {{WIDTH{1'b0}}, ov_q};
  assign sum     = {1'b0, a_q} + {1'b0, b_q} + ((alu_add) ? '0 : cin_ext);
  assign diff    = {1'b0, a_q} - {1'b0, b_q} - ((alu_sub) ? '0 : cin_ext);

  always_comb begin
    a_d   = alu0w ? alu0d : a_q;
    b_d   = alu1w ? alu1d : b_q;
    out_d = out_q;
    ov_d  = alu_flag_res ? 1'b0 : ov_q;
    eq_d  = alu_flag_res ? 1'b0 : eq_q;
    hlt_d = hlt_q | alu_hlt;
    // Flag clear is applied first so an operation's flag update overrides it.
    if (alu_add || alu_add_ov) begin
      out_d = sum[WIDTH-1:0];
      ov_d  = sum[WIDTH];
    end else if (alu_sub || alu_sub_ov) begin
      out_d = diff[WIDTH-1:0];
      ov_d  = diff[WIDTH];
    end else if (alu_and) begin
      out_d = a_q & b_q;
    end else if (alu_or) begin
      out_d = a_q | b_q;
    end else if (alu_not) begin
      out_d = ~a_q;
    end
    if (alu_cmp) eq_d = (a_q == b_q);
  end

  always_ff @(posedge clk) begin
    if (res) begin
      a_q   <= '0;
      b_q   <= '0;
      out_q <= '0;
      ov_q  <= 1'b0;
      eq_q  <= 1'b0;
      hlt_q <= 1'b0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      out_q <= out_d;
      ov_q  <= ov_d;
      eq_q  <= eq_d;
      hlt_q <= hlt_d;
    end
  end

  assign alu0o          = a_q;
  assign alu1o          = b_q;
  assign alu_out        = out_q;
  assign alu_flag_ov_o  = ov_q;
  assign alu_flag_eq_o  = eq_q;
  assign alu_flag_hlt_o = hlt_q;

endmodule

// File: tb/tb_goofy_alu.sv
// Directed bench for goofy_alu with hand-computed expectations.
module tb_goofy_alu;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         res, alu0w, alu1w;
  logic [W-1:0] alu0d, alu1d;
  logic         alu_add, alu_add_ov, alu_sub, alu_sub_ov;
  logic         alu_and, alu_or, alu_not, alu_cmp, alu_hlt, alu_flag_res;
  logic [W-1:0] alu0o, alu1o, alu_out;
  logic         ov, eq, hlt;
  int           n_cmp = 0;
  int           n_err = 0;

  goofy_alu #(.WIDTH(W)) dut (
    .clk(clk), .res(res),
    .alu0w(alu0w), .alu0d(alu0d), .alu0o(alu0o),
    .alu1w(alu1w), .alu1d(alu1d), .alu1o(alu1o),
    .alu_add(alu_add), .alu_add_ov(alu_add_ov), .alu_sub(alu_sub),
    .alu_sub_ov(alu_sub_ov), .alu_and(alu_and), .alu_or(alu_or),
    .alu_not(alu_not), .alu_cmp(alu_cmp), .alu_hlt(alu_hlt),
    .alu_flag_res(alu_flag_res), .alu_out(alu_out),
    .alu_flag_ov_o(ov), .alu_flag_eq_o(eq), .alu_flag_hlt_o(hlt)
  );

  always #5 clk = ~clk;

  task automatic clr();
    res = 0; alu0w = 0; alu1w = 0; alu0d = '0; alu1d = '0;
    alu_add = 0; alu_add_ov = 0; alu_sub = 0; alu_sub_ov = 0;
    alu_and = 0; alu_or = 0; alu_not = 0; alu_cmp = 0;
    alu_hlt = 0; alu_flag_res = 0;
  endtask

  // Apply current inputs for one edge, sample 1ns later, then drop them.
  task automatic tick();
    @(posedge clk);
    #1;
    clr();
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [W-1:0] a, input logic [W-1:0] b);
    alu0w = 1; alu0d = a; alu1w = 1; alu1d = b;
    tick();
  endtask

  initial begin
    clr();
    @(negedge clk);
    res = 1; alu0w = 1; alu0d = 8'hAA; alu_hlt = 1; alu_add = 1;
    tick();
    chk("rst_a", alu0o, 8'h00);  chk("rst_b", alu1o, 8'h00);
    chk("rst_out", alu_out, 8'h00); chk("rst_ov", ov, 0);
    chk("rst_eq", eq, 0);        chk("rst_hlt", hlt, 0);

    load(8'h05, 8'h03);
    chk("ld_a", alu0o, 8'h05); chk("ld_b", alu1o, 8'h03);
    alu_add = 1; tick(); chk("add_out", alu_out, 8'h08); chk("add_ov", ov, 0);
    alu_sub = 1; tick(); chk("sub_out", alu_out, 8'h02); chk("sub_ov", ov, 0);

    load(8'hFF, 8'h01);
    alu_add = 1;    tick(); chk("addc_out", alu_out, 8'h00); chk("addc_ov", ov, 1);
    alu_add_ov = 1; tick(); chk("addov_out", alu_out, 8'h01); chk("addov_ov", ov, 1);
    alu_flag_res = 1; tick(); chk("fres_ov", ov, 0); chk("fres_out", alu_out, 8'h01);

    load(8'h02, 8'h03);
    alu_sub = 1;    tick(); chk("subb_out", alu_out, 8'hFF); chk("subb_ov", ov, 1);
    alu_sub_ov = 1; tick(); chk("subov_out", alu_out, 8'hFE); chk("subov_ov", ov, 1);

    load(8'h3C, 8'h0F);
    alu_cmp = 1; tick(); chk("cmp_ne", eq, 0);
    alu1w = 1; alu1d = 8'h3C; tick();
    alu_cmp = 1; tick(); chk("cmp_eq", eq, 1); chk("cmp_out", alu_out, 8'hFE);
    chk("cmp_ov", ov, 1);
    alu_and = 1; tick(); chk("and_out", alu_out, 8'h3C); chk("and_ov", ov, 1);
    alu_or = 1;  tick(); chk("or_out", alu_out, 8'h3C);
    alu_not = 1; tick(); chk("not_out", alu_out, 8'hC3); chk("not_eq", eq, 1);

    load(8'h05, 8'h03);
    alu_add = 1; alu_sub = 1; alu_not = 1; tick(); chk("pri_add", alu_out, 8'h08);
    alu_sub = 1; alu_and = 1; tick(); chk("pri_sub", alu_out, 8'h02);
    alu_add = 1; alu_cmp = 1; tick();
    chk("par_out", alu_out, 8'h08); chk("par_eq", eq, 0);

    load(8'hFF, 8'h01);
    alu_flag_res = 1; alu_add = 1; tick();
    chk("fres_add_ov", ov, 1); chk("fres_add_out", alu_out, 8'h00);
    alu1w = 1; alu1d = 8'hFF; tick();
    alu_flag_res = 1; alu_cmp = 1; tick();
    chk("fres_cmp_eq", eq, 1); chk("fres_cmp_ov", ov, 0);
    tick();
    chk("idle_out", alu_out, 8'h00); chk("idle_ov", ov, 0); chk("idle_eq", eq, 1);

    load(8'h80, 8'h80);
    alu_flag_res = 1; tick(); chk("acc_clr_eq", eq, 0);
    alu_add_ov = 1; @(posedge clk); #1;
    chk("acc1_out", alu_out, 8'h00); chk("acc1_ov", ov, 1);
    tick(); chk("acc2_out", alu_out, 8'h01); chk("acc2_ov", ov, 1);

    load(8'h01, 8'h01);
    alu0w = 1; alu0d = 8'h10; alu_add = 1; tick();
    chk("wr_add_out", alu_out, 8'h02); chk("wr_add_a", alu0o, 8'h10);

    alu_hlt = 1; tick(); chk("hlt_set", hlt, 1);
    alu_flag_res = 1; tick(); chk("hlt_sticky", hlt, 1);
    tick(); chk("hlt_hold", hlt, 1);
    res = 1; alu_add = 1; alu1w = 1; alu1d = 8'h77; tick();
    chk("res_hlt", hlt, 0); chk("res_a", alu0o, 8'h00);
    chk("res_b", alu1o, 8'h00); chk("res_out", alu_out, 8'h00);
    chk("res_ov", ov, 0); chk("res_eq", eq, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/goofy_alu.md
GOOFY_ALU -- requirements
Module: goofy_alu

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the data width of operands, result and buses.
REQ-002 SHALL use one clock and a synchronous, active-high reset; all state SHALL update on the rising edge of clk.
REQ-003 clk  input  1  clock; all registers update on its rising edge.
REQ-004 res  input  1  synchronous, active-high reset.
REQ-005 alu0w  input  1  write enable for operand register A.
REQ-006 alu0d  input  WIDTH  data for operand register A.
REQ-007 alu0o  output  WIDTH  current contents of operand register A.
REQ-008 alu1w  input  1  write enable for operand register B.
REQ-009 alu1d  input  WIDTH  data for operand register B.
REQ-010 alu1o  output  WIDTH  current contents of operand register B.
REQ-011 alu_add, alu_add_ov, alu_sub, alu_sub_ov, alu_and, alu_or, alu_not, alu_cmp  input  1 each  operation strobes, level-sampled every clock.
REQ-012 alu_hlt  input  1  halt request.
REQ-013 alu_flag_res  input  1  flag clear request.
REQ-014 alu_out  output  WIDTH  registered result.
REQ-015 alu_flag_ov_o  output  1  carry/borrow flag (OV).
REQ-016 alu_flag_eq_o  output  1  equality flag (EQ).
REQ-017 alu_flag_hlt_o  output  1  sticky halt flag (HLT).

Function
REQ-018 On a rising edge with alu0w=1, A SHALL load alu0d; with alu1w=1, B SHALL load alu1d; both MAY load in the same cycle.
REQ-019 Operations on an edge SHALL use A, B and OV as they were before that edge; an operand written on the same edge is not seen until the next cycle.
REQ-020 The result SHALL appear on alu_out one cycle after the strobe edge and hold until the next result-producing operation or reset.
REQ-021 Operations SHALL behave as follows, with all arithmetic modulo 2^WIDTH:
- alu_add: out=A+B; OV=carry out.
- alu_add_ov: out=A+B+OV; OV=carry out.
- alu_sub: out=A-B; OV=borrow (A<B).
- alu_sub_ov: out=A-B-OV; OV=borrow.
- alu_and: out=A&B.
- alu_or: out=A|B.
- alu_not: out=~A.
- alu_and, alu_or and alu_not SHALL leave OV unchanged.
REQ-022 When alu_cmp=1, EQ SHALL be set to (A==B); alu_out and OV SHALL be unchanged.
REQ-023 EQ SHALL change only on alu_cmp, alu_flag_res or reset.
REQ-024 If several result strobes are high in one cycle, exactly one SHALL execute, in priority add > add_ov > sub > sub_ov > and > or > not.
REQ-025 alu_cmp SHALL execute independently of, and in the same cycle as, any result strobe.
REQ-026 When alu_flag_res=1, OV and EQ SHALL be cleared to 0.
REQ-027 If alu_flag_res=1 and an operation that updates OV or EQ is strobed in the same cycle, the operation's flag value SHALL win.
REQ-028 When alu_hlt=1, HLT SHALL be set to 1 and stay 1 until reset; alu_flag_res SHALL NOT clear HLT.
REQ-029 Strobes held high for multiple cycles SHALL re-execute every cycle; for example, add_ov held high accumulates the carry.
REQ-030 With no strobe active, all registers SHALL hold their values.

Reset
REQ-031 When res=1 at a rising edge, A, B, alu_out, OV, EQ and HLT SHALL all become 0, overriding every other input in that cycle.
REQ-032 Reset SHALL abort any operation in progress; no partial result is retained.

Verification
REQ-033 Write A=0x05, B=0x03, then pulse alu_add for one cycle -> alu_out=0x08, OV=0; next cycle pulse alu_sub -> alu_out=0x02, OV=0.
REQ-034 Load A=0xFF, B=0x01 and pulse alu_add -> alu_out=0x00, OV=1; then pulse alu_add_ov -> alu_out=0x01, OV=1; then pulse alu_flag_res -> OV=0, alu_out=0x01.
REQ-035 Load A=0x02, B=0x03 and pulse alu_sub -> alu_out=0xFF, OV=1; then pulse alu_sub_ov -> alu_out=0xFE, OV=1.
REQ-036 Load A=0x3C, B=0x0F and pulse alu_cmp -> EQ=0; load B=0x3C and pulse alu_cmp -> EQ=1, alu_out unchanged; then pulse alu_and -> 0x3C, alu_or -> 0x3C, alu_not -> 0xC3.
REQ-037 Pulse alu_hlt -> HLT=1; then pulse alu_flag_res -> HLT stays 1; then pulse res -> HLT=0, A=B=alu_out=0.
REQ-038 In one cycle write A=0x10 and strobe alu_add with previous A=0x01, B=0x01 -> alu_out=0x02, and A reads 0x10 on the next cycle.
